ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RISC-V core, between the ID stage and the MEM stage. It registers decoded operands in an ID/EX slot and selects the ALU inputs. It drives the combinational `alu` (a sibling instance at the CPU top), resolves branches and jumps, and captures results into an EX/MEM slot. Both sides use valid/ready handshakes, so back-pressure from MEM stalls ID without losing instructions.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: core clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1 / `id_ready` out 1: ID→EX handshake.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in 32 each: decoded operands.
- `id_alu_ctrl` in 4: ALU op encoding.
  - ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111.
  - Any other code yields result 0, zero 1.
- `id_src_a` in 1: ALU a source; 0 = rs1, 1 = pc.
- `id_src_b` in 1: ALU b source; 0 = rs2, 1 = imm.
- `id_br_type` in 3: NONE=000, BEQ=001, BNE=010, JAL=011, JALR=100; others are treated as NONE.
- `id_rd` in 5; `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: passed through to MEM.
- `alu_a`, `alu_b` out 32; `alu_ctrl` out 4: ALU drive, combinational from the ID/EX slot.
- `alu_result` in 32; `alu_zero` in 1; `alu_ready` in 1: ALU response.
- `mem_valid` out 1 / `mem_ready` in 1: EX→MEM handshake.
- `mem_result` out 32: ALU result, or pc+4 for JAL/JALR.
- `mem_store_data` out 32: rs2.
- `mem_rd` out 5; `mem_reg_write`, `mem_mem_read`, `mem_mem_write` out 1: registered copies of the pass-through fields.
- `redirect_valid` out 1; `redirect_pc` out 32: taken-branch/jump redirect to fetch/decode.

## Operation
- Two slots, each with its own valid bit:
  - X (ID/EX): operands and control.
  - M (EX/MEM): result and control.
- The ALU sees slot X only: `alu_a`/`alu_b` come from the source selects, and `alu_ctrl` = X.alu_ctrl.
- The X→M move fires when X.valid & alu_ready & (!M.valid | mem_ready). If alu_ready=0, X holds.
- M loads on that move. M clears when mem_valid & mem_ready and no new entry arrives.
- id_ready = !X.valid | (X→M move fires). Both slots can therefore stream at 1 instruction per cycle.
- Branch resolution in X:
  - BEQ taken when alu_zero=1; BNE taken when alu_zero=0. The decoder sets SUB with rs1/rs2 for both.
  - JAL always taken; target = pc + imm from a dedicated adder.
  - JALR always taken; target = alu_result & ~1. The decoder sets ADD with rs1/imm.
  - BEQ/BNE target = pc + imm from the dedicated adder.
- mem_result:
  - JAL/JALR: pc + 4, from a dedicated adder.
  - All other types: alu_result.
- Redirect:
  - redirect_valid is combinational, asserted in exactly the cycle the X→M move fires for a taken instruction. redirect_pc holds the target that cycle and is 0 otherwise.
  - On that edge, X loads invalid even if id_valid & id_ready: the wrong-path instruction is dropped.
  - ID flushes itself on redirect_valid.
- 32-bit adders wrap modulo 2^32 with no overflow flag.

## Timing
- Reset: every valid bit 0 and every registered output 0, immediately and asynchronously. This gives mem_valid=0, redirect_valid=0, and id_ready=1 as soon as rst_n is low.
- Latency: accept at edge N → mem_valid at N+1 (in slot M). Throughput is 1/cycle with mem_ready=1.
- While mem_valid=1 & mem_ready=0, every mem_* output holds stable.
- Reset asserted mid-operation discards both slots. No redirect is emitted for a discarded instruction.
- Simultaneous events:
  - M drains while X→M moves: M takes the new entry and stays valid.
  - X→M move and ID accept in the same cycle: X reloads, unless a redirect fires.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU op constants (4-bit);
  - branch type constants (3-bit);
  - the XLEN=32 constant.
- The ALU is not instantiated here; it is wired as a sibling at the CPU top.
- One sub-module: `ex_branch_unit`.
  - Combinational: takes br_type, pc, imm, alu_result, alu_zero.
  - Produces taken, target, and link (pc+4).

## Test plan
- **ADD with immediate.** rs1=5, imm=3, src_b=1, ADD, rd=7, mem_ready=1 → next cycle mem_valid=1, mem_result=0x8, mem_rd=7, redirect_valid=0.
- **Back-pressure.** Three back-to-back ADDs (results 1, 2, 3) with mem_ready=0 for 4 cycles → id_ready drops once both slots fill, mem_result holds 1. After release, results arrive as 1, 2, 3 with none lost or duplicated.
- **BEQ taken.** pc=0x100, rs1=rs2=0x10, imm=0x20, SUB → redirect_valid for 1 cycle with redirect_pc=0x120. The instruction accepted that cycle never appears on mem_valid.
- **BNE not taken.** Same operands as the BEQ case → no redirect, and the younger instruction completes.
- **JALR.** pc=0x200, rs1=0x1003, imm=4 → redirect_pc=0x1006, mem_result=0x204.
- **Invalid op and reset.** alu_ctrl=1111 → mem_result=0. Then rst_n low with both slots valid → mem_valid=0 and redirect_valid=0 immediately, with id_ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and slot types shared by the execute stage and its
// branch unit.
//   - XLEN            : datapath width (32)
//   - ALU_*           : 4-bit ALU op encodings driven on alu_ctrl
//   - BR_*            : 3-bit branch/jump type encodings
//   - ex_x_slot_t     : ID/EX slot payload (operands + control)
//   - ex_m_slot_t     : EX/MEM slot payload (result + control)
//   - br_is_jump()    : true for JAL/JALR, which write the link address back
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_JAL  = 3'b011;
    localparam logic [2:0] BR_JALR = 3'b100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_ctrl;
        logic            src_a;
        logic            src_b;
        logic [2:0]      br_type;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_x_slot_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_m_slot_t;

    localparam ex_x_slot_t X_SLOT_RST = {$bits(ex_x_slot_t){1'b0}};
    localparam ex_m_slot_t M_SLOT_RST = {$bits(ex_m_slot_t){1'b0}};

    function automatic logic br_is_jump(input logic [2:0] br_type);
        logic jump;
        case (br_type)
            BR_JAL:  jump = 1'b1;
            BR_JALR: jump = 1'b1;
            default: jump = 1'b0;
        endcase
        return jump;
    endfunction

endpackage

// File: rtl/ex_branch_unit.sv
// ex_branch_unit: combinational branch/jump resolution for the instruction in
// the ID/EX slot.
//   br_type_i    : branch type (unknown codes behave as NONE)
//   pc_i, imm_i  : instruction pc and immediate
//   alu_result_i : ALU output (JALR target source)
//   alu_zero_i   : ALU zero flag (BEQ/BNE condition, decoder sets SUB)
//   taken_o      : control flow leaves the sequential path
//   target_o     : redirect target
//   link_o       : pc + 4, written back by JAL/JALR
module ex_branch_unit
    import riscv_pkg::*;
(
    input  logic [2:0]      br_type_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            alu_zero_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] link_o
);

    logic [XLEN-1:0] pc_rel_target_s;

    // Dedicated adders, independent of the ALU; both wrap modulo 2^32.
    assign pc_rel_target_s = pc_i + imm_i;
    assign link_o          = pc_i + 32'd4;

    // Taken decision and target select per branch type.
    always_comb begin
        taken_o  = 1'b0;
        target_o = pc_rel_target_s;
        case (br_type_i)
            BR_BEQ:  taken_o = alu_zero_i;
            BR_BNE:  taken_o = ~alu_zero_i;
            BR_JAL:  taken_o = 1'b1;
            BR_JALR: begin
                taken_o  = 1'b1;
                // JALR clears bit 0 of the computed address.
                target_o = alu_result_i & ~32'd1;
            end
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID and MEM. Holds an ID/EX slot (X) that
// drives the sibling ALU, resolves branches, and an EX/MEM slot (M) whose
// contents are the registered mem_* outputs.
//   id_*             : ID->EX handshake and decoded operands/control
//   alu_a/b/ctrl     : combinational ALU drive from slot X
//   alu_result/zero  : ALU response; alu_ready gates the X->M move
//   mem_*            : EX->MEM handshake and registered slot M contents
//   redirect_valid/pc: taken branch/jump redirect, live only in the move cycle
module ex_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [31:0]     id_pc,
    input  logic [31:0]     id_rs1_data,
    input  logic [31:0]     id_rs2_data,
    input  logic [31:0]     id_imm,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_src_a,
    input  logic            id_src_b,
    input  logic [2:0]      id_br_type,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [31:0]     alu_result,
    input  logic            alu_zero,
    input  logic            alu_ready,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_result,
    output logic [31:0]     mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc
);

    ex_x_slot_t x_q, x_d;
    ex_m_slot_t m_q, m_d;
    logic       x_valid_q, x_valid_d;
    logic       m_valid_q, m_valid_d;

    logic            move_s;
    logic            accept_s;
    logic            taken_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] link_s;

    ex_branch_unit u_branch (
        .br_type_i    (x_q.br_type),
        .pc_i         (x_q.pc),
        .imm_i        (x_q.imm),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .taken_o      (taken_s),
        .target_o     (target_s),
        .link_o       (link_s)
    );

    assign alu_a    = x_q.src_a ? x_q.pc  : x_q.rs1;
    assign alu_b    = x_q.src_b ? x_q.imm : x_q.rs2;
    assign alu_ctrl = x_q.alu_ctrl;

    // X advances only when the ALU is ready and M is empty or draining.
    assign move_s   = x_valid_q & alu_ready & (~m_valid_q | mem_ready);
    assign id_ready = ~x_valid_q | move_s;
    assign accept_s = id_valid & id_ready;

    assign redirect_valid = move_s & taken_s;
    assign redirect_pc    = redirect_valid ? target_s : 32'd0;

    assign mem_valid      = m_valid_q;
    assign mem_result     = m_q.result;
    assign mem_store_data = m_q.store_data;
    assign mem_rd         = m_q.rd;
    assign mem_reg_write  = m_q.reg_write;
    assign mem_mem_read   = m_q.mem_read;
    assign mem_mem_write  = m_q.mem_write;

    // Next state of the ID/EX slot: a redirect squashes the wrong-path accept.
    always_comb begin
        x_valid_d = x_valid_q;
        x_d       = x_q;
        if (redirect_valid) begin
            x_valid_d = 1'b0;
        end else if (accept_s) begin
            x_valid_d   = 1'b1;
            x_d.pc        = id_pc;
            x_d.rs1       = id_rs1_data;
            x_d.rs2       = id_rs2_data;
            x_d.imm       = id_imm;
            x_d.alu_ctrl  = id_alu_ctrl;
            x_d.src_a     = id_src_a;
            x_d.src_b     = id_src_b;
            x_d.br_type   = id_br_type;
            x_d.rd        = id_rd;
            x_d.reg_write = id_reg_write;
            x_d.mem_read  = id_mem_read;
            x_d.mem_write = id_mem_write;
        end else if (move_s) begin
            x_valid_d = 1'b0;
        end else begin
            x_valid_d = x_valid_q;
        end
    end

    // Next state of the EX/MEM slot: a move overrides a drain in the same cycle.
    always_comb begin
        m_valid_d = m_valid_q;
        m_d       = m_q;
        if (move_s) begin
            m_valid_d      = 1'b1;
            m_d.result     = br_is_jump(x_q.br_type) ? link_s : alu_result;
            m_d.store_data = x_q.rs2;
            m_d.rd         = x_q.rd;
            m_d.reg_write  = x_q.reg_write;
            m_d.mem_read   = x_q.mem_read;
            m_d.mem_write  = x_q.mem_write;
        end else if (m_valid_q && mem_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Slot registers, cleared asynchronously so reset discards in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid_q <= 1'b0;
            m_valid_q <= 1'b0;
            x_q       <= X_SLOT_RST;
            m_q       <= M_SLOT_RST;
        end else begin
            x_valid_q <= x_valid_d;
            m_valid_q <= m_valid_d;
            x_q       <= x_d;
            m_q       <= m_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_ctrl;
    logic        id_src_a, id_src_b;
    logic [2:0]  id_br_type;
    logic [4:0]  id_rd;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_ready;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_br_type(id_br_type),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sibling ALU as it sits at the CPU top.
    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = alu_a << alu_b[4:0];
            4'b0110: alu_result = alu_a >> alu_b[4:0];
            4'b0111: alu_result = $signed(alu_a) >>> alu_b[4:0];
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm,
                             input logic [3:0] ctrl, input logic sa, input logic sb,
                             input logic [2:0] br, input logic [4:0] rd, input logic rw);
        id_pc = pc; id_rs1_data = rs1; id_rs2_data = rs2; id_imm = imm;
        id_alu_ctrl = ctrl; id_src_a = sa; id_src_b = sb; id_br_type = br;
        id_rd = rd; id_reg_write = rw; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_valid = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b want 0", redirect_valid); end
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL reset_id_ready: got %b want 1", id_ready); end
        n_cmp++; if (mem_result !== 32'd0) begin n_err++; $display("FAIL reset_mem_result: got %h want 0", mem_result); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add_imm();
        @(negedge clk);
        mem_ready = 1'b1;
        set_instr(32'h40, 32'd5, 32'hABCD, 32'd3, 4'b0000, 1'b0, 1'b1, 3'b000, 5'd7, 1'b1);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL add_id_ready: got %b want 1", id_ready); end
        @(posedge clk);
        @(negedge clk) id_valid = 1'b0;
        #1;
        n_cmp++; if (alu_a !== 32'd5) begin n_err++; $display("FAIL add_alu_a: got %h want 5", alu_a); end
        n_cmp++; if (alu_b !== 32'd3) begin n_err++; $display("FAIL add_alu_b: got %h want 3", alu_b); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL add_redirect: got %b want 0", redirect_valid); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b1) begin n_err++; $display("FAIL add_mem_valid: got %b want 1", mem_valid); end
        n_cmp++; if (mem_result !== 32'h8) begin n_err++; $display("FAIL add_result: got %h want 8", mem_result); end
        n_cmp++; if (mem_rd !== 5'd7) begin n_err++; $display("FAIL add_rd: got %0d want 7", mem_rd); end
        n_cmp++; if (mem_store_data !== 32'hABCD) begin n_err++; $display("FAIL add_store: got %h want abcd", mem_store_data); end
        n_cmp++; if (mem_reg_write !== 1'b1) begin n_err++; $display("FAIL add_reg_write: got %b want 1", mem_reg_write); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", mem_valid); end
    endtask

    task automatic test_alu_stall();
        @(negedge clk);
        alu_ready = 1'b0;
        set_instr(32'h0, 32'd10, 32'd0, 32'd20, 4'b0000, 1'b0, 1'b1, 3'b000, 5'd3, 1'b1);
        @(posedge clk);
        @(negedge clk) id_valid = 1'b0;
        #1;
        n_cmp++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL stall_id_ready: got %b want 0", id_ready); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL stall_mem_valid: got %b want 0", mem_valid); end
        @(negedge clk) alu_ready = 1'b1;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", id_ready); end
        @(posedge clk) #1;
        n_cmp++; if (mem_result !== 32'd30 || mem_valid !== 1'b1) begin n_err++; $display("FAIL stall_result: got %h/%b want 1e/1", mem_result, mem_valid); end
        @(posedge clk) #1;
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        mem_ready = 1'b0;
        set_instr(32'h0, 32'd0, 32'd0, 32'd1, 4'b0000, 1'b0, 1'b1, 3'b000, 5'd1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_instr(32'h4, 32'd1, 32'd0, 32'd1, 4'b0000, 1'b0, 1'b1, 3'b000, 5'd2, 1'b1);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one_slot: got %b want 1", id_ready); end
        @(posedge clk);
        @(negedge clk);
        set_instr(32'h8, 32'd2, 32'd0, 32'd1, 4'b0000, 1'b0, 1'b1, 3'b000, 5'd3, 1'b1);
        #1;
        n_cmp++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", id_ready); end
        n_cmp++; if (mem_result !== 32'd1) begin n_err++; $display("FAIL bp_first: got %h want 1", mem_result); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            n_cmp++; if (mem_valid !== 1'b1 || mem_result !== 32'd1) begin n_err++; $display("FAIL bp_hold%0d: got %b/%h want 1/1", i, mem_valid, mem_result); end
            n_cmp++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d: got %b want 0", i, id_ready); end
        end
        @(negedge clk) mem_ready = 1'b1;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", id_ready); end
        n_cmp++; if (mem_result !== 32'd1) begin n_err++; $display("FAIL bp_out1: got %h want 1", mem_result); end
        @(posedge clk);
        @(negedge clk) id_valid = 1'b0;
        #1;
        n_cmp++; if (mem_valid !== 1'b1 || mem_result !== 32'd2) begin n_err++; $display("FAIL bp_out2: got %b/%h want 1/2", mem_valid, mem_result); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b1 || mem_result !== 32'd3) begin n_err++; $display("FAIL bp_out3: got %b/%h want 1/3", mem_valid, mem_result); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", mem_valid); end
    endtask

    task automatic test_beq_taken();
        @(negedge clk);
        set_instr(32'h100, 32'h10, 32'h10, 32'h20, 4'b0001, 1'b0, 1'b0, 3'b001, 5'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_instr(32'h104, 32'h55, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1, 3'b000, 5'd9, 1'b1);
        #1;
        n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_redirect: got %b want 1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h120) begin n_err++; $display("FAIL beq_target: got %h want 120", redirect_pc); end
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL beq_id_ready: got %b want 1", id_ready); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b1 || mem_reg_write !== 1'b0) begin n_err++; $display("FAIL beq_in_m: got %b/%b want 1/0", mem_valid, mem_reg_write); end
        n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin n_err++; $display("FAIL beq_one_cycle: got %b/%h want 0/0", redirect_valid, redirect_pc); end
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL beq_squash_x: got %b want 1", id_ready); end
        @(negedge clk) id_valid = 1'b0;
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL beq_wrong_path: got %b want 0", mem_valid); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL beq_wrong_path2: got %b want 0", mem_valid); end
    endtask

    task automatic test_bne_not_taken();
        @(negedge clk);
        set_instr(32'h100, 32'h10, 32'h10, 32'h20, 4'b0001, 1'b0, 1'b0, 3'b010, 5'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_instr(32'h104, 32'h55, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1, 3'b000, 5'd9, 1'b1);
        #1;
        n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin n_err++; $display("FAIL bne_redirect: got %b/%h want 0/0", redirect_valid, redirect_pc); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b1 || mem_result !== 32'd0) begin n_err++; $display("FAIL bne_result: got %b/%h want 1/0", mem_valid, mem_result); end
        @(negedge clk) id_valid = 1'b0;
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b1 || mem_result !== 32'h55 || mem_rd !== 5'd9) begin n_err++; $display("FAIL bne_younger: got %b/%h/%0d want 1/55/9", mem_valid, mem_result, mem_rd); end
        @(posedge clk) #1;
    endtask

    task automatic test_jumps();
        @(negedge clk);
        set_instr(32'h200, 32'h1003, 32'd0, 32'd4, 4'b0000, 1'b0, 1'b1, 3'b100, 5'd1, 1'b1);
        @(posedge clk);
        @(negedge clk) id_valid = 1'b0;
        #1;
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1006) begin n_err++; $display("FAIL jalr_target: got %b/%h want 1/1006", redirect_valid, redirect_pc); end
        @(posedge clk) #1;
        n_cmp++; if (mem_result !== 32'h204 || mem_rd !== 5'd1) begin n_err++; $display("FAIL jalr_link: got %h/%0d want 204/1", mem_result, mem_rd); end
        @(negedge clk);
        set_instr(32'h300, 32'd0, 32'd0, 32'h40, 4'b0000, 1'b1, 1'b1, 3'b011, 5'd5, 1'b1);
        @(posedge clk);
        @(negedge clk) id_valid = 1'b0;
        #1;
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h340) begin n_err++; $display("FAIL jal_target: got %b/%h want 1/340", redirect_valid, redirect_pc); end
        @(posedge clk) #1;
        n_cmp++; if (mem_result !== 32'h304) begin n_err++; $display("FAIL jal_link: got %h want 304", mem_result); end
        @(negedge clk);
        set_instr(32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 4'b0000, 1'b1, 1'b1, 3'b011, 5'd5, 1'b1);
        @(posedge clk);
        @(negedge clk) id_valid = 1'b0;
        #1;
        n_cmp++; if (redirect_pc !== 32'h4) begin n_err++; $display("FAIL jal_wrap_target: got %h want 4", redirect_pc); end
        @(posedge clk) #1;
        n_cmp++; if (mem_result !== 32'h0) begin n_err++; $display("FAIL jal_wrap_link: got %h want 0", mem_result); end
        @(posedge clk) #1;
    endtask

    task automatic test_invalid_and_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        set_instr(32'h0, 32'd5, 32'd3, 32'd0, 4'b1111, 1'b0, 1'b0, 3'b000, 5'd4, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_instr(32'h10, 32'd1, 32'd0, 32'd1, 4'b0000, 1'b0, 1'b1, 3'b011, 5'd6, 1'b1);
        #1;
        n_cmp++; if (alu_ctrl !== 4'hF) begin n_err++; $display("FAIL inv_alu_ctrl: got %h want f", alu_ctrl); end
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b1 || mem_result !== 32'd0 || mem_rd !== 5'd4) begin n_err++; $display("FAIL inv_result: got %b/%h/%0d want 1/0/4", mem_valid, mem_result, mem_rd); end
        @(negedge clk) id_valid = 1'b0;
        #1;
        n_cmp++; if (redirect_valid !== 1'b0 || id_ready !== 1'b0) begin n_err++; $display("FAIL inv_blocked_jal: got %b/%b want 0/0", redirect_valid, id_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_valid !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_async: got %b/%b want 0/0", mem_valid, redirect_valid); end
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL rst_id_ready: got %b want 1", id_ready); end
        n_cmp++; if (mem_result !== 32'd0 || mem_rd !== 5'd0) begin n_err++; $display("FAIL rst_outputs: got %h/%0d want 0/0", mem_result, mem_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk) #1;
        n_cmp++; if (mem_valid !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_discard: got %b/%b want 0/0", mem_valid, redirect_valid); end
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; mem_ready = 1'b1; alu_ready = 1'b1;
        id_pc = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
        id_alu_ctrl = 4'd0; id_src_a = 1'b0; id_src_b = 1'b0; id_br_type = 3'd0;
        id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        test_reset();
        test_add_imm();
        test_alu_stall();
        test_back_pressure();
        test_beq_taken();
        test_bne_not_taken();
        test_jumps();
        test_invalid_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
